// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the JTAG master.
//   - command op encodings (jtag_op_e)
//   - master FSM state encoding (jtag_state_e)
//   - TMS preamble patterns (LSB is driven first) and their lengths
package jtag_pkg;

    typedef enum logic [1:0] {
        JTAG_OP_RESET   = 2'b00,
        JTAG_OP_IR      = 2'b01,
        JTAG_OP_DR      = 2'b10,
        JTAG_OP_RUNTEST = 2'b11
    } jtag_op_e;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PRE,
        SHIFT,
        POST,
        DONE
    } jtag_state_e;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [2:0] PRE_DR        = 3'b001;
    localparam int         PRE_DR_LEN    = 3;
    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] PRE_IR        = 4'b0011;
    localparam int         PRE_IR_LEN    = 4;
    // Five TMS=1 cycles reach Test-Logic-Reset from anywhere, then back to Run-Test/Idle
    localparam logic [5:0] PRE_RESET     = 6'b011111;
    localparam int         PRE_RESET_LEN = 6;
    // Exit1 -> Update -> Run-Test/Idle: TMS 1 then 0
    localparam int         POST_LEN      = 2;

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK waveform generator.
// Each TCK cycle is CLK_DIV clocks low followed by CLK_DIV clocks high.
// The first enabled cycle after being idle counts as a falling edge so that
// the master can drive its first TMS bit one clock after leaving idle.
// Ports:
//   CLK       system clock
//   TRST      asynchronous active-low reset
//   en        run the generator; when low TCK is parked low
//   tck       generated test clock
//   fall_stb  this CLK edge starts a TCK low half (drive TMS/TDI now)
//   rise_stb  this CLK edge drives TCK high (sample TDO now)
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic TRST,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             tck_reg;
    logic             active_reg;
    logic             half_end;

    assign half_end = (cnt_reg == CNT_W'(CLK_DIV - 1));
    assign fall_stb = en && (!active_reg || (tck_reg && half_end));
    assign rise_stb = en && active_reg && !tck_reg && half_end;
    assign tck      = tck_reg;

    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            cnt_reg    <= '0;
            tck_reg    <= 1'b0;
            active_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg    <= '0;
            tck_reg    <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
            if (!active_reg) begin
                cnt_reg <= '0;
            end else if (half_end) begin
                cnt_reg <= '0;
                tck_reg <= !tck_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG initiator.
// Turns single-beat commands (TAP reset, IR scan, DR scan, run-test) into
// TMS/TDI sequences, samples TDO during the shift phase and always leaves
// the target TAP in Run-Test/Idle.
// Configuration macro: JTAG_MASTER_RUNTEST_EN -- when defined, op 11 issues
// cmd_len TCK cycles with TMS=0; otherwise op 11 completes without any TCK.
// Ports:
//   CLK, TRST              system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op/cmd_len/cmd_data  op, bit count (clamped to DATA_W), TDI bits LSB first
//   rsp_valid/rsp_data     one-cycle completion pulse, captured TDO (held)
//   TCK_O/TMS_O/TDI_O/TDO_I  JTAG pins
module jtag_master
    import jtag_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              TCK_O,
    output logic              TMS_O,
    output logic              TDI_O,
    input  logic              TDO_I
);

    jtag_state_e       state_reg, state_next;
    logic              tms_reg, tms_next;
    logic              tdi_reg, tdi_next;
    logic [LEN_W-1:0]  idx_reg, idx_next;         // bit counter, reused per phase
    logic [LEN_W-1:0]  len_reg, len_next;
    logic              scan_reg, scan_next;       // op has a non-empty shift phase
    logic [7:0]        pre_sh_reg, pre_sh_next;   // preamble TMS bits, shifted out LSB first
    logic [LEN_W-1:0]  pre_len_reg, pre_len_next;
    logic [DATA_W-1:0] data_sh_reg, data_sh_next;
    logic [DATA_W-1:0] mask_reg, mask_next;       // one-hot: capture slot of the current bit
    logic [DATA_W-1:0] cap_reg, cap_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;

    logic             tck_en;
    logic             fall_stb;
    logic             rise_stb;
    logic             accept;
    logic             pre_done;
    logic [LEN_W-1:0] len_eff;

    assign tck_en = (state_reg == INIT) || (state_reg == PRE) ||
                    (state_reg == SHIFT) || (state_reg == POST);

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .CLK      (CLK),
        .TRST     (TRST),
        .en       (tck_en),
        .tck      (TCK_O),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    assign cmd_ready = (state_reg == IDLE) || (state_reg == DONE);
    assign rsp_valid = (state_reg == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign pre_done  = (idx_reg == pre_len_reg);
    assign len_eff   = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
    assign TMS_O     = tms_reg;
    assign TDI_O     = tdi_reg;
    assign rsp_data  = rsp_data_reg;

    // State register and datapath registers
    always_ff @(posedge CLK or negedge TRST) begin
        if (!TRST) begin
            state_reg    <= INIT;
            tms_reg      <= 1'b1;
            tdi_reg      <= 1'b0;
            idx_reg      <= '0;
            len_reg      <= '0;
            scan_reg     <= 1'b0;
            pre_sh_reg   <= 8'(PRE_RESET);
            pre_len_reg  <= LEN_W'(PRE_RESET_LEN);
            data_sh_reg  <= '0;
            mask_reg     <= '0;
            cap_reg      <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tms_reg      <= tms_next;
            tdi_reg      <= tdi_next;
            idx_reg      <= idx_next;
            len_reg      <= len_next;
            scan_reg     <= scan_next;
            pre_sh_reg   <= pre_sh_next;
            pre_len_reg  <= pre_len_next;
            data_sh_reg  <= data_sh_next;
            mask_reg     <= mask_next;
            cap_reg      <= cap_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    // Next-state logic: every phase advances only on a TCK falling strobe
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:  if (fall_stb && pre_done) state_next = IDLE;
            IDLE:  if (accept) state_next = PRE;
            PRE:   if (fall_stb && pre_done) state_next = scan_reg ? SHIFT : DONE;
            SHIFT: if (fall_stb && (idx_reg == len_reg)) state_next = POST;
            POST:  if (fall_stb && (idx_reg == LEN_W'(POST_LEN))) state_next = DONE;
            DONE:  state_next = accept ? PRE : IDLE;
            default: state_next = INIT;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        tms_next      = tms_reg;
        tdi_next      = tdi_reg;
        idx_next      = idx_reg;
        len_next      = len_reg;
        scan_next     = scan_reg;
        pre_sh_next   = pre_sh_reg;
        pre_len_next  = pre_len_reg;
        data_sh_next  = data_sh_reg;
        mask_next     = mask_reg;
        cap_next      = cap_reg;
        rsp_data_next = rsp_data_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    len_next     = len_eff;
                    data_sh_next = cmd_data;
                    cap_next     = '0;
                    mask_next    = DATA_W'(1);
                    idx_next     = '0;
                    scan_next    = 1'b0;
                    pre_sh_next  = '0;
                    pre_len_next = '0;
                    // A zero-length scan keeps pre_len=0 and scan=0, so it
                    // completes on the first strobe without any TCK.
                    case (jtag_op_e'(cmd_op))
                        JTAG_OP_RESET: begin
                            pre_sh_next  = 8'(PRE_RESET);
                            pre_len_next = LEN_W'(PRE_RESET_LEN);
                        end
                        JTAG_OP_IR: begin
                            if (len_eff != '0) begin
                                scan_next    = 1'b1;
                                pre_sh_next  = 8'(PRE_IR);
                                pre_len_next = LEN_W'(PRE_IR_LEN);
                            end
                        end
                        JTAG_OP_DR: begin
                            if (len_eff != '0) begin
                                scan_next    = 1'b1;
                                pre_sh_next  = 8'(PRE_DR);
                                pre_len_next = LEN_W'(PRE_DR_LEN);
                            end
                        end
                        JTAG_OP_RUNTEST: begin
`ifdef JTAG_MASTER_RUNTEST_EN
                            // zero pattern: len_eff idle cycles with TMS=0
                            pre_len_next = len_eff;
`else
                            pre_len_next = '0;
`endif
                        end
                        default: pre_len_next = '0;
                    endcase
                end
            end
            INIT, PRE: begin
                if (fall_stb) begin
                    if (!pre_done) begin
                        tms_next    = pre_sh_reg[0];
                        pre_sh_next = pre_sh_reg >> 1;
                        idx_next    = idx_reg + LEN_W'(1);
                    end else begin
                        idx_next = '0;
                        if (state_reg == PRE) begin
                            if (scan_reg) begin
                                // first shift bit goes out on the same fall
                                tms_next     = (len_reg == LEN_W'(1));
                                tdi_next     = data_sh_reg[0];
                                data_sh_next = data_sh_reg >> 1;
                                idx_next     = LEN_W'(1);
                            end else begin
                                rsp_data_next = cap_reg;
                            end
                        end
                    end
                end
            end
            SHIFT: begin
                if (rise_stb && TDO_I) begin
                    cap_next = cap_reg | mask_reg;
                end
                if (fall_stb) begin
                    if (idx_reg != len_reg) begin
                        tms_next     = ((idx_reg + LEN_W'(1)) == len_reg);
                        tdi_next     = data_sh_reg[0];
                        data_sh_next = data_sh_reg >> 1;
                        mask_next    = mask_reg << 1;
                        idx_next     = idx_reg + LEN_W'(1);
                    end else begin
                        tms_next = 1'b1;
                        tdi_next = 1'b0;
                        idx_next = LEN_W'(1);
                    end
                end
            end
            POST: begin
                if (fall_stb) begin
                    if (idx_reg != LEN_W'(POST_LEN)) begin
                        tms_next = 1'b0;
                        idx_next = idx_reg + LEN_W'(1);
                    end else begin
                        rsp_data_next = cap_reg;
                        idx_next      = '0;
                    end
                end
            end
            default: begin
                idx_next = idx_reg;
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed, table-driven bench for jtag_master
// (DATA_W=32, CLK_DIV=2). TDO is looped back from TDI one clock later,
// optionally inverted, so captured data is predictable.
module tb_jtag_master;
    import jtag_pkg::*;

    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 6;
`ifdef JTAG_MASTER_RUNTEST_EN
    localparam int RT_TCK = 10;
`else
    localparam int RT_TCK = 0;
`endif

    logic              CLK = 1'b0;
    logic              TRST = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              TCK_O, TMS_O, TDI_O, TDO_I;
    logic              tdi_d = 1'b0;
    logic              inv_tdo = 1'b0;

    jtag_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .CLK(CLK), .TRST(TRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .TCK_O(TCK_O), .TMS_O(TMS_O), .TDI_O(TDI_O), .TDO_I(TDO_I)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) tdi_d <= TDI_O;
    assign TDO_I = tdi_d ^ inv_tdo;

    // TCK rise monitor: history of TMS/TDI seen at every rising TCK edge
    int   rise_cnt = 0;
    logic tms_hist [0:2047];
    logic tdi_hist [0:2047];
    always @(posedge TCK_O) begin
        if (rise_cnt < 2048) begin
            tms_hist[rise_cnt] = TMS_O;
            tdi_hist[rise_cnt] = TDI_O;
        end
        rise_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic        inv;
        int          tck;
        logic [63:0] tms;
        logic [31:0] rsp;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] seq_of(input int base, input int n, input bit use_tdi);
        logic [63:0] s = '0;
        for (int k = 0; k < n && k < 64; k++) begin
            if (base + k < 2048) s[k] = use_tdi ? tdi_hist[base + k] : tms_hist[base + k];
        end
        return s;
    endfunction

    // Present a command (assumes called just after a CLK edge), then count
    // edges from the accept edge until rsp_valid is seen.
    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input logic inv, output int lat, output int base);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(posedge CLK); #1; w++;
        end
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        inv_tdo   = inv;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        base      = rise_cnt;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(posedge CLK); #1; lat++;
        end
    endtask

    // After TRST release: ready 25 edges later, TMS 1,1,1,1,1,0 on 6 rises
    task automatic wait_init(input string tag, inout logic seen_rsp);
        int n = 0;
        int b;
        @(negedge CLK);
        TRST = 1'b1;
        b = rise_cnt;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge CLK); #1; n++;
            if (rsp_valid === 1'b1) seen_rsp = 1'b1;
        end
        check({tag, "_ready_edge"}, 64'(n), 64'd25);
        check({tag, "_tck_rises"}, 64'(rise_cnt - b), 64'd6);
        check({tag, "_tms_seq"}, seq_of(b, rise_cnt - b, 1'b0), 64'h1F);
        check({tag, "_tms_idle"}, 64'(TMS_O), 64'd0);
    endtask

    initial begin
        int   lat, base, elen, pre;
        logic seen;
        logic [63:0] mask;

        vecs[0] = '{JTAG_OP_DR,      6'd8,  32'h000000A5, 1'b0, 13, 64'h0000_0000_0000_0C01, 32'h000000A5};
        vecs[1] = '{JTAG_OP_IR,      6'd4,  32'h00000003, 1'b0, 10, 64'h0000_0000_0000_0183, 32'h00000003};
        vecs[2] = '{JTAG_OP_DR,      6'd32, 32'hDEADBEEF, 1'b0, 37, 64'h0000_000C_0000_0001, 32'hDEADBEEF};
        vecs[3] = '{JTAG_OP_DR,      6'd40, 32'h12345678, 1'b0, 37, 64'h0000_000C_0000_0001, 32'h12345678};
        vecs[4] = '{JTAG_OP_IR,      6'd1,  32'h00000001, 1'b0, 7,  64'h0000_0000_0000_0033, 32'h00000001};
        vecs[5] = '{JTAG_OP_DR,      6'd0,  32'hFFFFFFFF, 1'b0, 0,  64'h0,                   32'h00000000};
        vecs[6] = '{JTAG_OP_RESET,   6'd9,  32'hFFFFFFFF, 1'b0, 6,  64'h0000_0000_0000_001F, 32'h00000000};
        vecs[7] = '{JTAG_OP_DR,      6'd5,  32'hFFFFFFFF, 1'b0, 10, 64'h0000_0000_0000_0181, 32'h0000001F};
        vecs[8] = '{JTAG_OP_DR,      6'd8,  32'h0000000F, 1'b1, 13, 64'h0000_0000_0000_0C01, 32'h000000F0};

        // ---- reset values and INIT sequence ----
        TRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tck", 64'(TCK_O), 64'd0);
        check("rst_tms", 64'(TMS_O), 64'd1);
        check("rst_tdi", 64'(TDI_O), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        seen = 1'b0;
        wait_init("init", seen);

        // ---- table-driven commands ----
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].inv, lat, base);
            elen = (vecs[i].len > 6'd32) ? 32 : int'(vecs[i].len);
            pre  = (vecs[i].op == JTAG_OP_DR) ? 3 : (vecs[i].op == JTAG_OP_IR) ? 4 : 0;
            $display("vec %0d: op=%0d len=%0d data=0x%08h -> lat=%0d rises=%0d rsp=0x%08h",
                     i, vecs[i].op, vecs[i].len, vecs[i].data, lat, rise_cnt - base, rsp_data);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(1 + 2 * CLK_DIV * vecs[i].tck));
            check($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].rsp));
            check($sformatf("v%0d_ready_on_rsp", i), 64'(cmd_ready), 64'd1);
            check($sformatf("v%0d_tck_low_on_rsp", i), 64'(TCK_O), 64'd0);
            check($sformatf("v%0d_tck_rises", i), 64'(rise_cnt - base), 64'(vecs[i].tck));
            check($sformatf("v%0d_tms_seq", i), seq_of(base, rise_cnt - base, 1'b0), vecs[i].tms);
            if (pre != 0 && elen != 0) begin
                mask = (64'd1 << elen) - 64'd1;
                check($sformatf("v%0d_tdi_seq", i),
                      (seq_of(base, rise_cnt - base, 1'b1) >> pre) & mask,
                      {32'd0, vecs[i].data} & mask);
            end
            @(posedge CLK); #1;
            check($sformatf("v%0d_rsp_pulse_end", i), 64'(rsp_valid), 64'd0);
            check($sformatf("v%0d_rsp_held", i), 64'(rsp_data), 64'(vecs[i].rsp));
        end

        // ---- reset during SHIFT bit 3 of a DR scan ----
        inv_tdo   = 1'b0;
        cmd_op    = JTAG_OP_DR;
        cmd_len   = 6'd8;
        cmd_data  = 32'hA5;
        cmd_valid = 1'b1;
        base      = rise_cnt;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (rise_cnt - base < 7 && lat < 200) begin
            @(posedge CLK); #1; lat++;
        end
        check("midrst_reached_bit3", 64'(rise_cnt - base), 64'd7);
        TRST = 1'b0;
        #1;
        $display("midrst: TRST asserted after %0d rises, TCK=%0b TMS=%0b", rise_cnt - base, TCK_O, TMS_O);
        check("midrst_tck", 64'(TCK_O), 64'd0);
        check("midrst_tms", 64'(TMS_O), 64'd1);
        check("midrst_ready", 64'(cmd_ready), 64'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        wait_init("replay", seen);
        check("midrst_no_rsp", 64'(seen), 64'd0);

        // ---- run-test followed by a back-to-back DR scan ----
        issue(JTAG_OP_RUNTEST, 6'd10, 32'hFFFFFFFF, 1'b0, lat, base);
        $display("runtest: lat=%0d rises=%0d rsp=0x%08h", lat, rise_cnt - base, rsp_data);
        check("rt_latency", 64'(lat), 64'(1 + 2 * CLK_DIV * RT_TCK));
        check("rt_tck_rises", 64'(rise_cnt - base), 64'(RT_TCK));
        check("rt_tms_seq", seq_of(base, rise_cnt - base, 1'b0), 64'd0);
        check("rt_rsp_data", 64'(rsp_data), 64'd0);
        issue(JTAG_OP_DR, 6'd8, 32'h000000A5, 1'b0, lat, base);
        $display("b2b dr: lat=%0d rises=%0d rsp=0x%08h", lat, rise_cnt - base, rsp_data);
        check("b2b_latency", 64'(lat), 64'd53);
        check("b2b_rsp_data", 64'(rsp_data), 64'hA5);
        check("b2b_tms_seq", seq_of(base, rise_cnt - base, 1'b0), 64'hC01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
